seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial pattern detector, the next generation of the fixed 1001 Mealy detector. Pattern length and pattern are set by parameters. The pattern can also be reloaded at run time.
Selectable overlapping or non-overlapping detection, with Mealy and Moore match outputs provided together. A saturating match counter is included.
Sits on a 1-bit serial input stream inside the sequential-circuit exercises and their testbenches.

Parameters:
N, 4, pattern length in bits (N >= 2)
PATTERN, 4'b1001, reset value of the pattern register; MSB is the first bit received
CNT_W, 8, width of the match counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
x  input  1  serial data bit, sampled on rising edge of clk
en  input  1  bit-valid; x is consumed only when en=1
overlap  input  1  1 = overlapping detection, 0 = non-overlapping
load  input  1  load pat_in into pattern register
pat_in  input  N  new pattern; MSB is the first bit
mealy_out  output  1  combinational match flag for the current x
moore_out  output  1  registered match flag, one cycle after the Mealy match
match_count  output  CNT_W  number of matches, saturating

Behaviour:
- State held in registers:
  - pat[N-1:0], the pattern.
  - hist[N-2:0], the last N-1 accepted bits; newest bit in the LSB.
  - fill, the count of valid history bits, ranging 0..N-1 and saturating at N-1.
  - moore_out.
  - match_count.
- Reset (rising edge with reset=1):
  - pat=PATTERN, hist=0, fill=0, moore_out=0, match_count=0.
  - mealy_out=0 while reset=1.
- Priority order: reset > load > en.
- Load (load=1, reset=0):
  - pat<=pat_in; hist<=0; fill<=0; moore_out<=0; match_count is kept.
  - mealy_out=0 during that cycle. The x on that cycle is discarded.
- Match condition (combinational): match = en & ~load & ~reset & (fill==N-1) & ({hist,x}==pat).
- mealy_out = match. It is valid in the same cycle as the final pattern bit, before the edge.
- On the edge with en=1 (no reset or load):
  - hist<=({hist,x})[N-2:0].
  - If match & ~overlap: fill<=0, so the next match needs N fresh bits.
  - Otherwise: fill<=min(fill+1, N-1).
- moore_out<=match on every edge (no reset or load). It is high for exactly one cycle per match, one cycle after mealy_out.
- With en=0: hist and fill hold, mealy_out=0, moore_out<=0.
- match_count:
  - Increments on each edge where match=1.
  - Holds at 2^CNT_W-1 and does not wrap.
- Changing overlap mid-stream takes effect at the next match decision. History is not cleared.
- Reset mid-pattern discards partial history. A complete new pattern is required after reset.

Test Plan:
- Reset: hold reset=1 for 2 cycles with x=1, en=1. Then: mealy_out=0, moore_out=0, match_count=0, pat=1001.
- Overlap mode, N=4, pattern 1001: overlap=1, en=1, stream 1,0,0,1,0,0,1.
  - mealy_out=1 during bit 4 and bit 7.
  - moore_out=1 in the cycles after bits 4 and 7.
  - match_count=2.
- Non-overlap mode, same stream with overlap=0: only bit 4 matches; match_count=1. Appending bits 0,0,1 (1001 after bit 7) gives match_count=2 at bit 10.
- en gap: send 1,0, then en=0 for 3 cycles (x toggling), then 0,1 with en=1. Response: one match on the final bit; mealy_out=0 throughout the gap.
- Runtime load:
  - load=1 with pat_in=0110 mid-stream; hist is cleared, match_count is kept.
  - Stream 1,0,0,1 then gives no match. Stream 0,1,1,0 then gives a match and match_count+1.
  - load asserted in the same cycle as a would-be match gives no match.
- Saturation: CNT_W=2, overlap=1, stream 1,0,0,1,0,0,1,0,0,1,0,0,1,0,0,1 (5 matches). match_count reaches 3 and stays at 3; moore_out still pulses on every match.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: runtime-loadable pattern, overlapping or
// non-overlapping detection, Mealy and Moore match flags, saturating match counter.
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1001,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    input  logic             overlap,
    input  logic             load,
    input  logic [N-1:0]     pat_in,
    output logic             mealy_out,
    output logic             moore_out,
    output logic [CNT_W-1:0] match_count
);

    localparam int               FW       = $clog2(N);
    localparam logic [FW-1:0]    FILL_MAX = FW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [N-1:0]     pat_r;
    logic [N-1:0]     pat_n_s;
    logic [N-2:0]     hist_r;
    logic [N-2:0]     hist_n_s;
    logic [FW-1:0]    fill_r;
    logic [FW-1:0]    fill_n_s;
    logic             moore_r;
    logic             moore_n_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n_s;
    logic [N-1:0]     window_s;
    logic             match_s;

    // The window is the last N-1 accepted bits followed by the bit on the wire now.
    assign window_s = {hist_r, x};
    assign match_s  = en & ~load & ~reset & (fill_r == FILL_MAX) & (window_s == pat_r);

    assign mealy_out   = match_s;
    assign moore_out   = moore_r;
    assign match_count = cnt_r;

    // Next-state logic for pattern, history, fill level, Moore flag and counter.
    always_comb begin
        pat_n_s   = pat_r;
        hist_n_s  = hist_r;
        fill_n_s  = fill_r;
        moore_n_s = match_s;
        cnt_n_s   = cnt_r;

        if (load) begin
            pat_n_s  = pat_in;
            hist_n_s = {(N-1){1'b0}};
            fill_n_s = {FW{1'b0}};
        end else if (en) begin
            hist_n_s = window_s[N-2:0];
            // A non-overlapping match forces the next one to start from fresh bits.
            if (match_s && !overlap) begin
                fill_n_s = {FW{1'b0}};
            end else if (fill_r != FILL_MAX) begin
                fill_n_s = fill_r + FW'(1);
            end else begin
                fill_n_s = fill_r;
            end
        end else begin
            hist_n_s = hist_r;
            fill_n_s = fill_r;
        end

        if (match_s && (cnt_r != CNT_MAX)) begin
            cnt_n_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_n_s = cnt_r;
        end
    end

    // State registers with synchronous reset; load clears the Moore flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_r   <= PATTERN;
            hist_r  <= {(N-1){1'b0}};
            fill_r  <= {FW{1'b0}};
            moore_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (load) begin
            pat_r   <= pat_n_s;
            hist_r  <= hist_n_s;
            fill_r  <= fill_n_s;
            moore_r <= 1'b0;
            cnt_r   <= cnt_r;
        end else begin
            pat_r   <= pat_n_s;
            hist_r  <= hist_n_s;
            fill_r  <= fill_n_s;
            moore_r <= moore_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seq_detector_param;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         x;
    logic         en;
    logic         overlap;
    logic         load;
    logic [N-1:0] pat_in;
    logic         mealy_out;
    logic         moore_out;
    logic [7:0]   match_count;
    logic         mealy_out2;
    logic         moore_out2;
    logic [1:0]   match_count2;

    seq_detector_param #(.N(N), .PATTERN(4'b1001), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap), .load(load),
        .pat_in(pat_in), .mealy_out(mealy_out), .moore_out(moore_out),
        .match_count(match_count)
    );

    seq_detector_param #(.N(N), .PATTERN(4'b1001), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .x(x), .en(en), .overlap(overlap), .load(load),
        .pat_in(pat_in), .mealy_out(mealy_out2), .moore_out(moore_out2),
        .match_count(match_count2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the accepted bits since the last clear, the pattern, and
    // an unbounded match tally that each counter width saturates on its own.
    bit           mq[$];
    logic [N-1:0] m_pat;
    bit           m_moore;
    int           m_cnt;
    bit           armed = 1'b0;
    bit           mt;

    function automatic bit model_match();
        int w;
        if (reset || load || !en) return 1'b0;
        if (mq.size() < N - 1) return 1'b0;
        w = 0;
        for (int i = mq.size() - (N - 1); i < mq.size(); i++) w = (w << 1) | int'(mq[i]);
        w = (w << 1) | int'(x);
        return (w == int'(m_pat));
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            mt = model_match();
            if (reset) begin
                mq.delete();
                m_pat   = 4'b1001;
                m_moore = 1'b0;
                m_cnt   = 0;
                armed   = 1'b1;
            end else if (load) begin
                mq.delete();
                m_pat   = pat_in;
                m_moore = 1'b0;
            end else begin
                m_moore = mt;
                if (mt) m_cnt++;
                if (en) begin
                    if (mt && !overlap) begin
                        mq.delete();
                    end else begin
                        mq.push_back(x);
                        if (mq.size() > N - 1) void'(mq.pop_front());
                    end
                end
            end
            @(negedge clk);
            if (armed) begin
                chk("mealy",       int'(mealy_out),    int'(model_match()));
                chk("moore",       int'(moore_out),    int'(m_moore));
                chk("count",       int'(match_count),  sat(m_cnt, 255));
                chk("mealy_sat",   int'(mealy_out2),   int'(model_match()));
                chk("moore_sat",   int'(moore_out2),   int'(m_moore));
                chk("count_sat",   int'(match_count2), sat(m_cnt, 3));
            end
        end
    end

    // Samples taken mid-cycle after each driven step.
    logic       s_mealy;
    logic       s_moore;
    logic [7:0] s_cnt;
    logic [1:0] s_cnt2;
    logic [31:0] mv;
    logic [31:0] mo;

    task automatic step(input bit r, input bit e, input bit xi, input bit ov,
                        input bit ld, input logic [N-1:0] pi);
        @(posedge clk);
        #1;
        reset = r; en = e; x = xi; overlap = ov; load = ld; pat_in = pi;
        #3;
        s_mealy = mealy_out;
        s_moore = moore_out;
        s_cnt   = match_count;
        s_cnt2  = match_count2;
        mv = {mv[30:0], s_mealy};
        mo = {mo[30:0], s_moore};
    endtask

    task automatic bit_step(input bit e, input bit xi, input bit ov);
        step(1'b0, e, xi, ov, 1'b0, 4'b0000);
    endtask

    task automatic send(input logic [31:0] seq, input int len, input bit ov);
        for (int i = len - 1; i >= 0; i--) bit_step(1'b1, seq[i], ov);
    endtask

    task automatic do_reset();
        repeat (2) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
            chk("mealy_in_reset", int'(s_mealy), 0);
        end
        bit_step(1'b0, 1'b0, 1'b0);
        chk("reset_moore", int'(s_moore), 0);
        chk("reset_count", int'(s_cnt), 0);
        chk("reset_mealy", int'(s_mealy), 0);
        mv = 32'd0;
        mo = 32'd0;
    endtask

    bit ov_r;

    initial begin
        reset = 1'b1; en = 1'b0; x = 1'b0; overlap = 1'b0; load = 1'b0; pat_in = 4'b0000;
        mv = 32'd0; mo = 32'd0;

        // Overlapping: 1001001 matches on bits 4 and 7.
        do_reset();
        send(32'b1001001, 7, 1'b1);
        bit_step(1'b0, 1'b0, 1'b1);
        chk("ovl_mealy", int'(mv[7:0]), 'b00010010);
        chk("ovl_moore", int'(mo[7:0]), 'b00001001);
        chk("ovl_count", int'(s_cnt), 2);

        // Non-overlapping: only bits 4 and 10 match.
        do_reset();
        send(32'b1001001001, 10, 1'b0);
        bit_step(1'b0, 1'b0, 1'b0);
        chk("novl_mealy", int'(mv[10:0]), 'b00010000010);
        chk("novl_count", int'(s_cnt), 2);

        // en gap in the middle of the pattern.
        do_reset();
        bit_step(1'b1, 1'b1, 1'b1);
        bit_step(1'b1, 1'b0, 1'b1);
        bit_step(1'b0, 1'b1, 1'b1);
        bit_step(1'b0, 1'b0, 1'b1);
        bit_step(1'b0, 1'b1, 1'b1);
        bit_step(1'b1, 1'b0, 1'b1);
        bit_step(1'b1, 1'b1, 1'b1);
        bit_step(1'b0, 1'b0, 1'b1);
        chk("gap_mealy", int'(mv[7:0]), 'b00000010);
        chk("gap_moore", int'(s_moore), 1);
        chk("gap_count", int'(s_cnt), 1);

        // Runtime load of 0110; count survives, load blocks a would-be match.
        do_reset();
        send(32'b10010, 5, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        chk("load_mealy", int'(s_mealy), 0);
        send(32'b1001, 4, 1'b1);
        chk("load_keeps_count", int'(s_cnt), 1);
        send(32'b0110, 4, 1'b1);
        send(32'b011, 3, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110);
        chk("load_blocks_match", int'(s_mealy), 0);
        bit_step(1'b0, 1'b0, 1'b1);
        chk("load_mealy_trace", int'(mv[18:0]), 'h08020);
        chk("load_count", int'(s_cnt), 2);
        chk("load_moore", int'(s_moore), 0);

        // Five overlapping matches: wide counter reads 5, 2-bit counter sticks at 3.
        do_reset();
        send(32'h9249, 16, 1'b1);
        bit_step(1'b0, 1'b0, 1'b1);
        chk("sat_count2", int'(s_cnt2), 3);
        chk("sat_count8", int'(s_cnt), 5);
        chk("sat_moore_pulses", $countones(mo[16:0]), 5);

        // Randomized traffic against the model.
        ov_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) ov_r = ~ov_r;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ov_r,
                 ($urandom_range(0, 99) < 2),
                 4'($urandom_range(0, 15)));
        end

        bit_step(1'b0, 1'b0, 1'b0);
        bit_step(1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
